// File: rtl/bus_arbiter_ctrl.sv
// Two-master / three-slave bus arbiter with one-hot slave select, hold
// timeout and split/resume support. arbiter_state exposes the FSM code.
module bus_arbiter_ctrl #(
  parameter bit ROUND_ROBIN    = 1'b0,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic [1:0] m1_sel,
  input  logic [1:0] m2_sel,
  input  logic       m1_done,
  input  logic       m2_done,
  input  logic       s_split,
  input  logic       s_resume_m1,
  input  logic       s_resume_m2,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic [2:0] slave_en,
  output logic       m1_split_pend,
  output logic       m2_split_pend,
  output logic       timeout_pulse,
  output logic       addr_err,
  output logic [2:0] arbiter_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    M1_BUS   = 3'd1,
    M2_BUS   = 3'd2,
    HANDOVER = 3'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             g1_nxt, g2_nxt;
  logic [2:0]       sen_nxt;
  logic             tout_nxt, aerr_nxt;
  logic             res1, res2, res1_nxt, res2_nxt;
  logic             pend1_nxt, pend2_nxt;
  logic             last_m2, last_m2_nxt;

  // Arbitration helpers
  logic       elig1, elig2, cand1, cand2, rr_m1, win_any, win_m1;
  logic       alt_elig;
  logic [1:0] win_sel, alt_sel;
  logic       split1, split2;

  function automatic logic [2:0] onehot(input logic [1:0] sel);
    case (sel)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  assign arbiter_state = state;

  // Winner selection: resume flag first, then fixed or round-robin tie-break
  always_comb begin
    elig1 = m1_req & ~m1_split_pend;
    elig2 = m2_req & ~m2_split_pend;
    cand1 = elig1 & res1;
    cand2 = elig2 & res2;
    // Round robin: the last-granted master loses a tie
    rr_m1 = ROUND_ROBIN ? last_m2 : 1'b1;
    win_any = elig1 | elig2;
    if (cand1 != cand2)
      win_m1 = cand1;
    else if (cand1 & cand2)
      win_m1 = rr_m1;
    else if (elig1 & elig2)
      win_m1 = rr_m1;
    else
      win_m1 = elig1;
    win_sel  = win_m1 ? m1_sel : m2_sel;
    alt_sel  = win_m1 ? m2_sel : m1_sel;
    alt_elig = win_m1 ? elig2 : elig1;
  end

  // Next-state, grant, slave-enable, counter and split/resume bookkeeping
  always_comb begin
    state_nxt   = IDLE;
    cnt_nxt     = '0;
    g1_nxt      = 1'b0;
    g2_nxt      = 1'b0;
    sen_nxt     = 3'b000;
    tout_nxt    = 1'b0;
    aerr_nxt    = 1'b0;
    last_m2_nxt = last_m2;
    split1      = 1'b0;
    split2      = 1'b0;

    case (state)
      IDLE: begin
        if (win_any) begin
          if (win_sel != 2'd3) begin
            g1_nxt = win_m1;
            g2_nxt = ~win_m1;
            sen_nxt = onehot(win_sel);
          end else begin
            // Invalid winner: flag it and hand the bus to the other master
            aerr_nxt = 1'b1;
            if (alt_elig && alt_sel != 2'd3) begin
              g1_nxt  = ~win_m1;
              g2_nxt  = win_m1;
              sen_nxt = onehot(alt_sel);
            end
          end
          if (g1_nxt) begin
            state_nxt   = M1_BUS;
            last_m2_nxt = 1'b0;
          end else if (g2_nxt) begin
            state_nxt   = M2_BUS;
            last_m2_nxt = 1'b1;
          end
        end
      end
      M1_BUS, M2_BUS: begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        g1_nxt    = (state == M1_BUS);
        g2_nxt    = (state == M2_BUS);
        sen_nxt   = slave_en;
        if ((state == M1_BUS) ? m1_done : m2_done) begin
          state_nxt = HANDOVER;
        end else if (s_split) begin
          state_nxt = HANDOVER;
          split1    = (state == M1_BUS);
          split2    = (state == M2_BUS);
        end else if (cnt == CNT_LAST) begin
          state_nxt = HANDOVER;
          tout_nxt  = 1'b1;
        end
        if (state_nxt == HANDOVER) begin
          g1_nxt  = 1'b0;
          g2_nxt  = 1'b0;
          sen_nxt = 3'b000;
          cnt_nxt = '0;
        end
      end
      HANDOVER: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    // A split recorded this cycle wins over a simultaneous resume
    pend1_nxt = m1_split_pend;
    res1_nxt  = res1;
    if (split1) begin
      pend1_nxt = 1'b1;
    end else if (s_resume_m1 && m1_split_pend) begin
      pend1_nxt = 1'b0;
      res1_nxt  = 1'b1;
    end
    if (g1_nxt && state == IDLE) res1_nxt = 1'b0;

    pend2_nxt = m2_split_pend;
    res2_nxt  = res2;
    if (split2) begin
      pend2_nxt = 1'b1;
    end else if (s_resume_m2 && m2_split_pend) begin
      pend2_nxt = 1'b0;
      res2_nxt  = 1'b1;
    end
    if (g2_nxt && state == IDLE) res2_nxt = 1'b0;
  end

  // State and registered outputs; last grant resets to m2 so m1 wins the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      m1_grant      <= 1'b0;
      m2_grant      <= 1'b0;
      slave_en      <= 3'b000;
      m1_split_pend <= 1'b0;
      m2_split_pend <= 1'b0;
      timeout_pulse <= 1'b0;
      addr_err      <= 1'b0;
      res1          <= 1'b0;
      res2          <= 1'b0;
      last_m2       <= 1'b1;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      m1_grant      <= g1_nxt;
      m2_grant      <= g2_nxt;
      slave_en      <= sen_nxt;
      m1_split_pend <= pend1_nxt;
      m2_split_pend <= pend2_nxt;
      timeout_pulse <= tout_nxt;
      addr_err      <= aerr_nxt;
      res1          <= res1_nxt;
      res2          <= res2_nxt;
      last_m2       <= last_m2_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Directed-vector bench for bus_arbiter_ctrl: one fixed-priority and one
// round-robin instance share the same stimulus; both use a 4-cycle timeout.
module tb_bus_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       m1_req, m2_req;
  logic [1:0] m1_sel, m2_sel;
  logic       m1_done, m2_done, s_split, s_resume_m1, s_resume_m2;

  logic       a_g1, a_g2, a_p1, a_p2, a_to, a_ae;
  logic [2:0] a_se, a_st;
  logic       b_g1, b_g2, b_p1, b_p2, b_to, b_ae;
  logic [2:0] b_se, b_st;

  int vecs = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bus_arbiter_ctrl #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(4), .CNT_W(8)) dut_fp (
    .clk(clk), .reset(reset),
    .m1_req(m1_req), .m2_req(m2_req), .m1_sel(m1_sel), .m2_sel(m2_sel),
    .m1_done(m1_done), .m2_done(m2_done), .s_split(s_split),
    .s_resume_m1(s_resume_m1), .s_resume_m2(s_resume_m2),
    .m1_grant(a_g1), .m2_grant(a_g2), .slave_en(a_se),
    .m1_split_pend(a_p1), .m2_split_pend(a_p2),
    .timeout_pulse(a_to), .addr_err(a_ae), .arbiter_state(a_st)
  );

  bus_arbiter_ctrl #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(4), .CNT_W(8)) dut_rr (
    .clk(clk), .reset(reset),
    .m1_req(m1_req), .m2_req(m2_req), .m1_sel(m1_sel), .m2_sel(m2_sel),
    .m1_done(m1_done), .m2_done(m2_done), .s_split(s_split),
    .s_resume_m1(s_resume_m1), .s_resume_m2(s_resume_m2),
    .m1_grant(b_g1), .m2_grant(b_g2), .slave_en(b_se),
    .m1_split_pend(b_p1), .m2_split_pend(b_p2),
    .timeout_pulse(b_to), .addr_err(b_ae), .arbiter_state(b_st)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks grant pair, slave enable and state of the fixed-priority instance
  task automatic chk_a(input string tag, input logic g1, input logic g2,
                       input logic [2:0] se, input logic [2:0] st);
    chk({tag, ".m1_grant"}, 32'(a_g1), 32'(g1));
    chk({tag, ".m2_grant"}, 32'(a_g2), 32'(g2));
    chk({tag, ".slave_en"}, 32'(a_se), 32'(se));
    chk({tag, ".state"},    32'(a_st), 32'(st));
  endtask

  initial begin
    reset = 1'b0;
    m1_req = 1'b0; m2_req = 1'b0; m1_sel = 2'd0; m2_sel = 2'd0;
    m1_done = 1'b0; m2_done = 1'b0; s_split = 1'b0;
    s_resume_m1 = 1'b0; s_resume_m2 = 1'b0;
    step(); step();
    reset = 1'b1;
    step();

    // Reset state
    chk_a("rst", 1'b0, 1'b0, 3'b000, 3'd0);
    chk("rst.timeout", 32'(a_to), 32'd0);
    chk("rst.addr_err", 32'(a_ae), 32'd0);
    chk("rst.pend", 32'({a_p1, a_p2}), 32'd0);

    // Fixed priority: m1 wins, then m2 after done + handover + idle
    m1_req = 1'b1; m2_req = 1'b1; m1_sel = 2'd1; m2_sel = 2'd2;
    step();
    chk_a("fp.grant1", 1'b1, 1'b0, 3'b010, 3'd1);
    m1_done = 1'b1; m1_req = 1'b0;
    step();
    m1_done = 1'b0;
    chk_a("fp.handover", 1'b0, 1'b0, 3'b000, 3'd3);
    step();
    chk_a("fp.idle", 1'b0, 1'b0, 3'b000, 3'd0);
    step();
    chk_a("fp.grant2", 1'b0, 1'b1, 3'b100, 3'd2);
    m2_done = 1'b1; m2_req = 1'b0;
    step();
    m2_done = 1'b0;
    step();
    chk("fp.back_idle", 32'(a_st), 32'd0);

    // Invalid address: lone m1 with sel 3
    m1_req = 1'b1; m1_sel = 2'd3;
    step();
    chk("ae.alone.addr_err", 32'(a_ae), 32'd1);
    chk_a("ae.alone", 1'b0, 1'b0, 3'b000, 3'd0);
    m1_req = 1'b0;
    step();
    chk("ae.alone.pulse_end", 32'(a_ae), 32'd0);

    // Invalid address winner, m2 valid: m2 granted in the same cycle
    m1_req = 1'b1; m1_sel = 2'd3; m2_req = 1'b1; m2_sel = 2'd0;
    step();
    chk("ae.alt.addr_err", 32'(a_ae), 32'd1);
    chk_a("ae.alt", 1'b0, 1'b1, 3'b001, 3'd2);
    chk("ae.alt.rr_grant", 32'(b_g2), 32'd1);
    m1_req = 1'b0; m2_done = 1'b1; m2_req = 1'b0;
    step();
    m2_done = 1'b0;
    chk("ae.alt.pulse_end", 32'(a_ae), 32'd0);
    step();

    // Split and resume
    m2_req = 1'b1; m2_sel = 2'd2;
    step();
    chk_a("sp.m2_own", 1'b0, 1'b1, 3'b100, 3'd2);
    m1_req = 1'b1; m1_sel = 2'd0; s_split = 1'b1;
    step();
    s_split = 1'b0;
    chk_a("sp.release", 1'b0, 1'b0, 3'b000, 3'd3);
    chk("sp.pend2", 32'(a_p2), 32'd1);
    step();
    chk("sp.idle", 32'(a_st), 32'd0);
    step();
    chk_a("sp.m1_own", 1'b1, 1'b0, 3'b001, 3'd1);
    s_resume_m2 = 1'b1;
    step();
    s_resume_m2 = 1'b0;
    chk("sp.pend2_clr", 32'(a_p2), 32'd0);
    m1_done = 1'b1;
    step();
    m1_done = 1'b0;
    step();
    step();
    chk_a("sp.resume_win", 1'b0, 1'b1, 3'b100, 3'd2);
    chk("sp.resume_win_rr", 32'(b_g2), 32'd1);
    m2_done = 1'b1; m2_req = 1'b0; m1_req = 1'b0;
    step();
    m2_done = 1'b0;
    step();

    // Timeout: grant for exactly 4 cycles, then forced release with pulse
    m1_req = 1'b1; m1_sel = 2'd2;
    step();
    m1_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to.hold%0d", i), 32'(a_g1), 32'd1);
      chk($sformatf("to.nopulse%0d", i), 32'(a_to), 32'd0);
      step();
    end
    chk_a("to.release", 1'b0, 1'b0, 3'b000, 3'd3);
    chk("to.pulse", 32'(a_to), 32'd1);
    step();
    chk("to.pulse_end", 32'(a_to), 32'd0);
    chk("to.idle", 32'(a_st), 32'd0);

    // Reset mid-transfer, asserted between edges
    m1_req = 1'b1; m1_sel = 2'd1;
    step();
    chk_a("mr.own", 1'b1, 1'b0, 3'b010, 3'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_a("mr.async", 1'b0, 1'b0, 3'b000, 3'd0);
    chk("mr.rr_grant", 32'(b_g1), 32'd0);
    m1_req = 1'b0;
    #2;
    reset = 1'b1;
    step();

    // Round robin: both requesting, done after 3 cycles each
    m1_req = 1'b1; m2_req = 1'b1; m1_sel = 2'd0; m2_sel = 2'd1;
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr.g1_%0d", k), 32'(b_g1), 32'((k % 2) == 0));
      chk($sformatf("rr.g2_%0d", k), 32'(b_g2), 32'((k % 2) == 1));
      step();
      step();
      if ((k % 2) == 0) m1_done = 1'b1; else m2_done = 1'b1;
      step();
      m1_done = 1'b0; m2_done = 1'b0;
      chk($sformatf("rr.handover%0d", k), 32'(b_st), 32'd3);
      step();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
